// File: rtl/lsu_pipe.sv
// lsu_pipe -- load/store unit stage between EX and WB.
//
// Purpose:
//   Captures one op from EX and forms the effective address (rdata1 + imm).
//   It builds byte strobes and replicated store data, then performs a single
//   outstanding request/acknowledge access on the data SRAM. Load data is
//   aligned and sign/zero-extended. The result is presented to WB with a
//   valid/ready handshake. Illegal sizes raise out_exc without touching
//   memory. A flush aborts the op; an access already accepted by memory is
//   drained first.
//
// Configuration macro:
//   MISALIGN_EXC_EN  defined   : misaligned half/word/dword raise out_exc.
//                    undefined : misaligned accesses go out as is. Only the
//                                in-line bytes are written or returned.
//
// Parameters:
//   XLEN  datapath width (32 or 64)
//   SW    strobe width in bytes (derived, XLEN/8)
//   OFFW  byte-offset address bits (derived, log2(SW))
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   in_valid/in_ready              EX-side handshake
//   lsu_op[6:0]                    {en, we, size[3:0]={d,w,h,b}, unsigned}
//   rdata1, rdata2, imm            base, store data, offset
//   in_rd                          destination tag (passed through)
//   flush                          kill the op in flight
//   data_sram_req/wr/wstrb/addr/wdata   request side of the data SRAM
//   data_sram_addr_ok/data_ok/rdata     accept, response and load data
//   out_valid/out_ready            WB-side handshake
//   out_rdata, out_rd              aligned load result (0 for stores), tag
//   out_exc, out_badaddr           exception flag and faulting address
module lsu_pipe #(
   parameter int XLEN = 64,
   parameter int SW   = XLEN / 8,
   parameter int OFFW = $clog2(SW)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      lsu_op,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic [XLEN-1:0] imm,
   input  logic [4:0]      in_rd,
   input  logic            flush,
   output logic            data_sram_req,
   output logic            data_sram_wr,
   output logic [SW-1:0]   data_sram_wstrb,
   output logic [XLEN-1:0] data_sram_addr,
   output logic [XLEN-1:0] data_sram_wdata,
   input  logic            data_sram_addr_ok,
   input  logic            data_sram_data_ok,
   input  logic [XLEN-1:0] data_sram_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rdata,
   output logic [4:0]      out_rd,
   output logic            out_exc,
   output logic [XLEN-1:0] out_badaddr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   // Size priority byte > half > word > dword; result is one-hot or zero.
   function automatic logic [3:0] size_sel(input logic [3:0] s);
      if (s[0])      return 4'b0001;
      else if (s[1]) return 4'b0010;
      else if (s[2]) return 4'b0100;
      else if (s[3]) return 4'b1000;
      else           return 4'b0000;
   endfunction

   function automatic logic size_illegal(input logic [3:0] s);
      logic onehot;
      onehot = (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
      return !onehot || ((XLEN == 32) && s[3]);
   endfunction

   function automatic logic misaligned(input logic [3:0] sel, input logic [OFFW-1:0] off);
      case (sel)
         4'b0010: return off[0];
         4'b0100: return off[1:0] != 2'b00;
         4'b1000: return off != '0;
         default: return 1'b0;
      endcase
   endfunction

   // Strobes are formed double-width and truncated so a misaligned access
   // keeps only the bytes that fall inside this data word.
   function automatic logic [SW-1:0] strobe(input logic [3:0] sel, input logic [OFFW-1:0] off);
      logic [2*SW-1:0] w;
      case (sel)
         4'b0001: w = {{(2*SW-1){1'b0}}, 1'b1} << off;
         4'b0010: w = {{(2*SW-2){1'b0}}, 2'b11} << off;
         4'b0100: w = {{(2*SW-4){1'b0}}, 4'hF} << off;
         4'b1000: w = '1;
         default: w = '0;
      endcase
      return w[SW-1:0];
   endfunction

   function automatic logic [XLEN-1:0] replicate(input logic [3:0] sel, input logic [XLEN-1:0] d);
      case (sel)
         4'b0001: return {(SW){d[7:0]}};
         4'b0010: return {(SW/2){d[15:0]}};
         4'b0100: return {(SW/4){d[31:0]}};
         default: return d;
      endcase
   endfunction

   // Shift the addressed byte to bit 0, keep the access width, then fill
   // the upper bits with the sign bit (or zero for unsigned loads).
   function automatic logic [XLEN-1:0] align_load(input logic [3:0] sel, input logic uns,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [XLEN-1:0] raw);
      logic [XLEN-1:0] s;
      logic [XLEN-1:0] m;
      logic            sb;
      s = raw >> {off, 3'b000};
      case (sel)
         4'b0001: begin m = XLEN'(8'hFF);         sb = s[7];      end
         4'b0010: begin m = XLEN'(16'hFFFF);      sb = s[15];     end
         4'b0100: begin m = XLEN'(32'hFFFF_FFFF); sb = s[31];     end
         default: begin m = '1;                   sb = s[XLEN-1]; end
      endcase
      return (s & m) | ((sb && !uns) ? ~m : '0);
   endfunction

   state_t            state_q;
   logic [6:0]        op_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [SW-1:0]     wstrb_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   res_q;
   logic              exc_q;
   logic [XLEN-1:0]   badaddr_q;
   logic              cancel_q;

   // Capture-side decode of the incoming op.
   logic [XLEN-1:0]   addr_d;
   logic [OFFW-1:0]   off_d;
   logic [3:0]        sel_d;
   logic              exc_d;
   logic [SW-1:0]     wstrb_d;
   logic [XLEN-1:0]   wdata_d;
   logic [XLEN-1:0]   load_res;

   assign addr_d = rdata1 + imm;
   assign off_d  = addr_d[OFFW-1:0];
   assign sel_d  = size_sel(lsu_op[4:1]);

`ifdef MISALIGN_EXC_EN
   assign exc_d = lsu_op[6] && (size_illegal(lsu_op[4:1]) || misaligned(sel_d, off_d));
`else
   assign exc_d = lsu_op[6] && size_illegal(lsu_op[4:1]);
`endif

   assign wstrb_d  = (lsu_op[6] && !exc_d) ? strobe(sel_d, off_d) : '0;
   assign wdata_d  = replicate(sel_d, rdata2);
   assign load_res = op_q[5] ? '0
                   : align_load(size_sel(op_q[4:1]), op_q[0], addr_q[OFFW-1:0], data_sram_rdata);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rd_q      <= '0;
         res_q     <= '0;
         exc_q     <= 1'b0;
         badaddr_q <= '0;
         cancel_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Flush wins over a simultaneous in_valid.
               if (!flush && in_valid) begin
                  op_q      <= lsu_op;
                  addr_q    <= addr_d;
                  wdata_q   <= wdata_d;
                  wstrb_q   <= wstrb_d;
                  rd_q      <= in_rd;
                  res_q     <= '0;
                  exc_q     <= exc_d;
                  badaddr_q <= exc_d ? addr_d : '0;
                  cancel_q  <= 1'b0;
                  state_q   <= (lsu_op[6] && !exc_d) ? REQ : DONE;
               end
            end
            REQ: begin
               if (data_sram_addr_ok) begin
                  if (data_sram_data_ok) begin
                     if (flush) begin
                        state_q <= IDLE;
                     end else begin
                        res_q   <= load_res;
                        state_q <= DONE;
                     end
                  end else begin
                     // Accepted by memory: a flush now must wait for data_ok.
                     cancel_q <= flush;
                     state_q  <= WAIT;
                  end
               end else if (flush) begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (data_sram_data_ok) begin
                  if (cancel_q || flush) begin
                     cancel_q <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     res_q   <= load_res;
                     state_q <= DONE;
                  end
               end else if (flush) begin
                  cancel_q <= 1'b1;
               end
            end
            DONE: begin
               if (flush || out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready        = (state_q == IDLE);
   assign data_sram_req   = (state_q == REQ);
   assign data_sram_wr    = (state_q == REQ) && op_q[5];
   assign data_sram_wstrb = wstrb_q;
   assign data_sram_addr  = addr_q;
   assign data_sram_wdata = wdata_q;
   assign out_valid       = (state_q == DONE);
   assign out_rdata       = res_q;
   assign out_rd          = rd_q;
   assign out_exc         = exc_q;
   assign out_badaddr     = badaddr_q;

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;

   logic        clk = 1'b0;
   logic        resetn;
   always #5 clk = ~clk;

   // XLEN=64 instance
   logic        in_valid, in_ready, flush, out_valid, out_ready, out_exc;
   logic [6:0]  lsu_op;
   logic [63:0] rdata1, rdata2, imm, addr, wdata, dram, out_rdata, out_badaddr;
   logic [4:0]  in_rd, out_rd;
   logic        req, wr, addr_ok, data_ok;
   logic [7:0]  wstrb;

   lsu_pipe #(.XLEN(64)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .lsu_op(lsu_op), .rdata1(rdata1), .rdata2(rdata2), .imm(imm), .in_rd(in_rd),
      .flush(flush), .data_sram_req(req), .data_sram_wr(wr), .data_sram_wstrb(wstrb),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok),
      .data_sram_data_ok(data_ok), .data_sram_rdata(dram), .out_valid(out_valid),
      .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd), .out_exc(out_exc),
      .out_badaddr(out_badaddr));

   // XLEN=32 instance
   logic        h_in_valid, h_in_ready, h_flush, h_out_valid, h_out_ready, h_out_exc;
   logic [6:0]  h_lsu_op;
   logic [31:0] h_rdata1, h_rdata2, h_imm, h_addr, h_wdata, h_dram, h_out_rdata, h_out_badaddr;
   logic [4:0]  h_in_rd, h_out_rd;
   logic        h_req, h_wr, h_addr_ok, h_data_ok;
   logic [3:0]  h_wstrb;

   lsu_pipe #(.XLEN(32)) dut32 (
      .clk(clk), .resetn(resetn), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .lsu_op(h_lsu_op), .rdata1(h_rdata1), .rdata2(h_rdata2), .imm(h_imm), .in_rd(h_in_rd),
      .flush(h_flush), .data_sram_req(h_req), .data_sram_wr(h_wr), .data_sram_wstrb(h_wstrb),
      .data_sram_addr(h_addr), .data_sram_wdata(h_wdata), .data_sram_addr_ok(h_addr_ok),
      .data_sram_data_ok(h_data_ok), .data_sram_rdata(h_dram), .out_valid(h_out_valid),
      .out_ready(h_out_ready), .out_rdata(h_out_rdata), .out_rd(h_out_rd), .out_exc(h_out_exc),
      .out_badaddr(h_out_badaddr));

   int n_cmp = 0;
   int n_fail = 0;

   // Observations gathered by run_op
   logic        o_req_seen, o_stable, o_hold_ok, o_timeout, o_wr, o_exc, o_after_valid, o_after_ready;
   logic [63:0] o_addr, o_wdata, o_rdata, o_bad;
   logic [7:0]  o_wstrb;
   logic [4:0]  o_rd;
   int          o_lat;

`ifdef MISALIGN_EXC_EN
   localparam bit MIS_ON = 1'b1;
`else
   localparam bit MIS_ON = 1'b0;
`endif

   function automatic logic [6:0] mkop(input logic en, we, input logic [3:0] sz, input logic uns);
      return {en, we, sz, uns};
   endfunction

   // Reference model: bytes touched by an access, expressed on whole bytes.
   function automatic logic [7:0] m_strb(input int nb, input int off);
      int t;
      if (nb == 8) return 8'hFF;
      t = ((1 << nb) - 1) << off;
      return t[7:0];
   endfunction

   function automatic logic [63:0] m_wdata(input logic [63:0] d, input int nb);
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = d[(i % nb)*8 +: 8];
      return w;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] raw, input int off, input int nb, input logic uns);
      logic [63:0] v, mask;
      v = raw >> (off * 8);
      if (nb < 8) begin
         mask = (64'd1 << (nb * 8)) - 64'd1;
         v = v & mask;
         if (!uns && (((v >> (nb * 8 - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic run_op(input logic [6:0] op, input logic [63:0] r1, r2, im, mem,
                         input logic [4:0] rd, input int a_dly, d_dly, rdy_dly);
      int req_cnt, wait_cnt;
      bit pend, done;
      o_req_seen = 0; o_stable = 1; o_hold_ok = 1; o_timeout = 0; o_lat = 0;
      o_addr = 0; o_wstrb = 0; o_wdata = 0; o_wr = 0; o_rdata = 0; o_exc = 0; o_bad = 0; o_rd = 0;
      o_after_valid = 1'bx; o_after_ready = 1'bx;
      lsu_op = op; rdata1 = r1; rdata2 = r2; imm = im; in_rd = rd; in_valid = 1; out_ready = 0;
      @(posedge clk); @(negedge clk);
      in_valid = 0;
      req_cnt = 0; wait_cnt = 0; pend = 0; done = 0;
      for (int c = 1; c <= 100 && !done; c++) begin
         addr_ok = 0; data_ok = 0;
         if (out_valid) begin
            done = 1; o_lat = c; o_rdata = out_rdata; o_exc = out_exc; o_bad = out_badaddr; o_rd = out_rd;
         end else begin
            if (req) begin
               if (!o_req_seen) begin
                  o_req_seen = 1; o_addr = addr; o_wstrb = wstrb; o_wdata = wdata; o_wr = wr;
               end else if (addr !== o_addr || wstrb !== o_wstrb || wdata !== o_wdata || wr !== o_wr) begin
                  o_stable = 0;
               end
               if (req_cnt == a_dly) begin
                  addr_ok = 1;
                  if (d_dly == 0) begin data_ok = 1; dram = mem; end
                  else begin pend = 1; wait_cnt = 0; end
               end
               req_cnt++;
            end else if (pend) begin
               wait_cnt++;
               if (wait_cnt == d_dly) begin data_ok = 1; dram = mem; pend = 0; end
            end
            @(posedge clk); @(negedge clk);
         end
      end
      addr_ok = 0; data_ok = 0;
      if (!done) begin
         o_timeout = 1;
         resetn = 0; @(negedge clk); resetn = 1; @(negedge clk);
         return;
      end
      for (int i = 0; i < rdy_dly; i++) begin
         @(posedge clk); @(negedge clk);
         if (out_valid !== 1'b1 || out_rdata !== o_rdata || out_exc !== o_exc) o_hold_ok = 0;
      end
      out_ready = 1;
      @(posedge clk); @(negedge clk);
      out_ready = 0;
      o_after_valid = out_valid; o_after_ready = in_ready;
   endtask

   task automatic test_reset;
      resetn = 0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0 || req !== 1'b0 || wr !== 1'b0 || out_exc !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl got valid=%b req=%b wr=%b exc=%b exp all 0", out_valid, req, wr, out_exc); end
      n_cmp++; if (wstrb !== 8'h0 || addr !== 64'h0 || wdata !== 64'h0 || out_rdata !== 64'h0 || out_badaddr !== 64'h0 || out_rd !== 5'h0) begin
         n_fail++; $display("FAIL reset_data got strb=%h addr=%h wdata=%h rdata=%h exp 0", wstrb, addr, wdata, out_rdata); end
      n_cmp++; if (h_in_ready !== 1'b1 || h_out_valid !== 1'b0 || h_req !== 1'b0) begin
         n_fail++; $display("FAIL reset_x32 got rdy=%b vld=%b req=%b exp 1/0/0", h_in_ready, h_out_valid, h_req); end
      @(negedge clk);
      resetn = 1;
      @(negedge clk);
   endtask

   task automatic test_store_byte;
      run_op(mkop(1, 1, 4'b0001, 0), 64'h1000, 64'hAB, 64'd3, 64'h0, 5'd7, 0, 1, 0);
      n_cmp++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL sb_timeout got=1 exp=0"); end
      n_cmp++; if (o_wstrb !== 8'h08) begin n_fail++; $display("FAIL sb_wstrb got=%h exp=08", o_wstrb); end
      n_cmp++; if (o_wdata !== 64'hABAB_ABAB_ABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got=%h exp=abab..ab", o_wdata); end
      n_cmp++; if (o_addr !== 64'h1003 || o_wr !== 1'b1) begin n_fail++; $display("FAIL sb_addr got=%h wr=%b exp=1003/1", o_addr, o_wr); end
      n_cmp++; if (o_rdata !== 64'h0 || o_lat !== 3 || o_rd !== 5'd7) begin
         n_fail++; $display("FAIL sb_out got rdata=%h lat=%0d rd=%0d exp 0/3/7", o_rdata, o_lat, o_rd); end
   endtask

   task automatic test_load_half;
      run_op(mkop(1, 0, 4'b0010, 0), 64'h2000, 64'h0, 64'd6, 64'h8001_0000_0000_0000, 5'd3, 0, 1, 0);
      n_cmp++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin n_fail++; $display("FAIL lh_rdata got=%h exp=ffffffffffff8001", o_rdata); end
      n_cmp++; if (o_addr !== 64'h2006 || o_wr !== 1'b0) begin n_fail++; $display("FAIL lh_addr got=%h wr=%b exp=2006/0", o_addr, o_wr); end
      run_op(mkop(1, 0, 4'b0010, 1), 64'h2000, 64'h0, 64'd6, 64'h8001_0000_0000_0000, 5'd3, 0, 0, 0);
      n_cmp++; if (o_rdata !== 64'h8001) begin n_fail++; $display("FAIL lhu_rdata got=%h exp=8001", o_rdata); end
   endtask

   task automatic test_req_hold;
      run_op(mkop(1, 0, 4'b0100, 0), 64'h3000, 64'h0, 64'h0, 64'h1234_5678_9ABC_DEF0, 5'd9, 3, 1, 2);
      n_cmp++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL hold_req_stable got=0 exp=1"); end
      n_cmp++; if (o_lat !== 6) begin n_fail++; $display("FAIL hold_latency got=%0d exp=6", o_lat); end
      n_cmp++; if (o_rdata !== 64'hFFFF_FFFF_9ABC_DEF0) begin n_fail++; $display("FAIL hold_lw_rdata got=%h exp=ffffffff9abcdef0", o_rdata); end
      n_cmp++; if (o_hold_ok !== 1'b1) begin n_fail++; $display("FAIL hold_out_stall got=0 exp=1"); end
      n_cmp++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_release got vld=%b rdy=%b exp 0/1", o_after_valid, o_after_ready); end
   endtask

   task automatic test_passthrough_and_illegal;
      run_op(mkop(0, 0, 4'b0000, 0), 64'h55, 64'h0, 64'h1, 64'h0, 5'd4, 0, 0, 0);
      n_cmp++; if (o_req_seen !== 1'b0 || o_lat !== 1 || o_exc !== 1'b0 || o_rd !== 5'd4) begin
         n_fail++; $display("FAIL nop got req=%b lat=%0d exc=%b rd=%0d exp 0/1/0/4", o_req_seen, o_lat, o_exc, o_rd); end
      run_op(mkop(1, 1, 4'b0011, 0), 64'h700, 64'h0, 64'h8, 64'h0, 5'd5, 0, 0, 0);
      n_cmp++; if (o_req_seen !== 1'b0 || o_lat !== 1 || o_exc !== 1'b1 || o_bad !== 64'h708) begin
         n_fail++; $display("FAIL badsize got req=%b lat=%0d exc=%b bad=%h exp 0/1/1/708", o_req_seen, o_lat, o_exc, o_bad); end
   endtask

   task automatic test_misalign;
      run_op(mkop(1, 1, 4'b0100, 0), 64'h1000, 64'hCAFE_F00D, 64'h2, 64'h0, 5'd2, 0, 1, 0);
      if (MIS_ON) begin
         n_cmp++; if (o_req_seen !== 1'b0 || o_exc !== 1'b1 || o_bad !== 64'h1002 || o_lat !== 1) begin
            n_fail++; $display("FAIL mis_exc got req=%b exc=%b bad=%h lat=%0d exp 0/1/1002/1", o_req_seen, o_exc, o_bad, o_lat); end
      end else begin
         n_cmp++; if (o_req_seen !== 1'b1 || o_wstrb !== 8'h3C || o_exc !== 1'b0 || o_addr !== 64'h1002) begin
            n_fail++; $display("FAIL mis_issue got req=%b strb=%h exc=%b addr=%h exp 1/3c/0/1002", o_req_seen, o_wstrb, o_exc, o_addr); end
      end
   endtask

   task automatic test_flush;
      // flush while waiting for data_ok
      lsu_op = mkop(1, 0, 4'b0100, 0); rdata1 = 64'h4000; imm = 0; in_valid = 1;
      @(posedge clk); @(negedge clk); in_valid = 0;
      n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL flw_req got=%b exp=1", req); end
      addr_ok = 1; @(posedge clk); @(negedge clk); addr_ok = 0;
      flush = 1; @(posedge clk); @(negedge clk); flush = 0;
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || req !== 1'b0) begin
         n_fail++; $display("FAIL flw_pending got rdy=%b vld=%b req=%b exp 0/0/0", in_ready, out_valid, req); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flw_still_busy got=%b exp=0", in_ready); end
      data_ok = 1; @(posedge clk); @(negedge clk); data_ok = 0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flw_drained got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
      // flush in REQ before addr_ok
      in_valid = 1; @(posedge clk); @(negedge clk); in_valid = 0;
      flush = 1; @(posedge clk); @(negedge clk); flush = 0;
      n_cmp++; if (req !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flr got req=%b rdy=%b exp 0/1", req, in_ready); end
      // flush in REQ together with addr_ok
      in_valid = 1; @(posedge clk); @(negedge clk); in_valid = 0;
      addr_ok = 1; flush = 1; @(posedge clk); @(negedge clk); addr_ok = 0; flush = 0;
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fla_wait got rdy=%b vld=%b exp 0/0", in_ready, out_valid); end
      data_ok = 1; @(posedge clk); @(negedge clk); data_ok = 0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fla_done got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
      // flush in DONE, and flush beating in_valid in IDLE
      lsu_op = mkop(0, 0, 4'b0000, 0); in_valid = 1; @(posedge clk); @(negedge clk); in_valid = 0;
      flush = 1; @(posedge clk); @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fld got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
      in_valid = 1; @(posedge clk); @(negedge clk); in_valid = 0; flush = 0;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flprio got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
   endtask

   task automatic test_spurious_and_reset;
      data_ok = 1; @(posedge clk); @(posedge clk); @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL spur_idle got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
      data_ok = 0;
      lsu_op = mkop(0, 0, 4'b0000, 0); in_valid = 1; @(posedge clk); @(negedge clk); in_valid = 0;
      data_ok = 1; @(posedge clk); @(negedge clk); data_ok = 0;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL spur_done got vld=%b exp=1", out_valid); end
      out_ready = 1; @(posedge clk); @(negedge clk); out_ready = 0;
      // reset in the middle of a request
      lsu_op = mkop(1, 1, 4'b1000, 0); rdata1 = 64'h8000; imm = 0; in_valid = 1;
      @(posedge clk); @(negedge clk); in_valid = 0;
      resetn = 0; #1;
      n_cmp++; if (req !== 1'b0 || in_ready !== 1'b1 || wstrb !== 8'h0) begin
         n_fail++; $display("FAIL midreset got req=%b rdy=%b strb=%h exp 0/1/00", req, in_ready, wstrb); end
      @(negedge clk); resetn = 1; @(negedge clk);
   endtask

   task automatic test_xlen32;
      h_lsu_op = mkop(1, 0, 4'b1000, 0); h_rdata1 = 32'h100; h_imm = 32'h8; h_in_valid = 1;
      @(posedge clk); @(negedge clk); h_in_valid = 0;
      n_cmp++; if (h_out_valid !== 1'b1 || h_out_exc !== 1'b1 || h_wstrb !== 4'h0 || h_req !== 1'b0 || h_out_badaddr !== 32'h108) begin
         n_fail++; $display("FAIL x32_ld got vld=%b exc=%b strb=%h req=%b bad=%h exp 1/1/0/0/108", h_out_valid, h_out_exc, h_wstrb, h_req, h_out_badaddr); end
      h_out_ready = 1; @(posedge clk); @(negedge clk); h_out_ready = 0;
      h_lsu_op = mkop(1, 0, 4'b0100, 0); h_rdata1 = 32'h200; h_imm = 0; h_in_valid = 1;
      @(posedge clk); @(negedge clk); h_in_valid = 0;
      n_cmp++; if (h_req !== 1'b1 || h_wstrb !== 4'hF) begin n_fail++; $display("FAIL x32_lw_req got req=%b strb=%h exp 1/f", h_req, h_wstrb); end
      h_addr_ok = 1; h_data_ok = 1; h_dram = 32'h8765_4321;
      @(posedge clk); @(negedge clk); h_addr_ok = 0; h_data_ok = 0;
      n_cmp++; if (h_out_valid !== 1'b1 || h_out_rdata !== 32'h8765_4321 || h_out_exc !== 1'b0) begin
         n_fail++; $display("FAIL x32_lw got vld=%b rdata=%h exc=%b exp 1/87654321/0", h_out_valid, h_out_rdata, h_out_exc); end
      h_out_ready = 1; @(posedge clk); @(negedge clk); h_out_ready = 0;
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         logic en, we, uns, illegal, exc_e, mem_e;
         logic [3:0]  sz;
         logic [63:0] r1, r2, im, mem, a_e, rd_e;
         logic [4:0]  rd;
         int nb, off, a_d, d_d, r_d;
         en = ($urandom_range(0, 7) != 0); we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         nb = 1 << $urandom_range(0, 3);
         sz = 4'(nb); illegal = 0;
         if ($urandom_range(0, 9) == 0) begin sz = ($urandom_range(0, 1) != 0) ? 4'b0110 : 4'b0000; illegal = 1; end
         r1 = {$urandom, $urandom}; im = {$urandom, $urandom}; r2 = {$urandom, $urandom}; mem = {$urandom, $urandom};
         rd = 5'($urandom_range(0, 31));
         a_d = $urandom_range(0, 3); d_d = $urandom_range(0, 3); r_d = $urandom_range(0, 2);
         a_e = r1 + im; off = int'(a_e[2:0]);
         exc_e = en && (illegal || (MIS_ON && (off % nb) != 0));
         mem_e = en && !exc_e;
         rd_e = (mem_e && !we) ? m_load(mem, off, nb, uns) : 64'h0;
         run_op(mkop(en, we, sz, uns), r1, r2, im, mem, rd, a_d, d_d, r_d);
         n_cmp++; if (o_timeout !== 1'b0 || o_req_seen !== mem_e) begin
            n_fail++; $display("FAIL rnd%0d_req got to=%b req=%b exp 0/%b", n, o_timeout, o_req_seen, mem_e); end
         if (mem_e) begin
            n_cmp++; if (o_addr !== a_e || o_wr !== we || o_stable !== 1'b1) begin
               n_fail++; $display("FAIL rnd%0d_addr got=%h wr=%b st=%b exp=%h/%b/1", n, o_addr, o_wr, o_stable, a_e, we); end
            if (we) begin
               n_cmp++; if (o_wstrb !== m_strb(nb, off) || o_wdata !== m_wdata(r2, nb)) begin
                  n_fail++; $display("FAIL rnd%0d_wr got strb=%h data=%h exp=%h/%h", n, o_wstrb, o_wdata, m_strb(nb, off), m_wdata(r2, nb)); end
            end
         end
         n_cmp++; if (o_rdata !== rd_e || o_exc !== exc_e || o_rd !== rd) begin
            n_fail++; $display("FAIL rnd%0d_out got rdata=%h exc=%b rd=%0d exp=%h/%b/%0d", n, o_rdata, o_exc, o_rd, rd_e, exc_e, rd); end
         if (exc_e) begin
            n_cmp++; if (o_bad !== a_e) begin n_fail++; $display("FAIL rnd%0d_bad got=%h exp=%h", n, o_bad, a_e); end
         end
         n_cmp++; if (o_lat !== (mem_e ? a_d + d_d + 2 : 1) || o_hold_ok !== 1'b1 || o_after_ready !== 1'b1 || o_after_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd%0d_timing got lat=%0d hold=%b rdy=%b vld=%b exp=%0d/1/1/0", n, o_lat, o_hold_ok, o_after_ready, o_after_valid, mem_e ? a_d + d_d + 2 : 1); end
      end
   endtask

   initial begin
      in_valid = 0; flush = 0; out_ready = 0; lsu_op = 0; rdata1 = 0; rdata2 = 0; imm = 0; in_rd = 0;
      addr_ok = 0; data_ok = 0; dram = 0;
      h_in_valid = 0; h_flush = 0; h_out_ready = 0; h_lsu_op = 0; h_rdata1 = 0; h_rdata2 = 0; h_imm = 0;
      h_in_rd = 0; h_addr_ok = 0; h_data_ok = 0; h_dram = 0;
      resetn = 0;
      @(negedge clk);
      test_reset;
      test_store_byte;
      test_load_half;
      test_req_hold;
      test_passthrough_and_illegal;
      test_misalign;
      test_flush;
      test_spurious_and_reset;
      test_xlen32;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/lsu_pipe.md
Name: lsu_pipe

Overview:
- Parametrised, handshaked successor to the combinational load/store address/strobe unit in the RV memory stage.
- Computes the effective address, byte strobes and replicated store data.
- Drives a request/acknowledge data-SRAM interface with one outstanding access, and aligns and extends load data.
- Flags misaligned accesses, accepts pipeline flush, and sits between EX and WB with valid/ready on both sides.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- SW, XLEN/8, strobe width in bytes (derived; do not override).
- OFFW, log2(SW), number of byte-offset address bits (derived).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  op present from EX
- in_ready  out  1  block can accept an op
- lsu_op  in  7  {en, we, size[3:0] one-hot {dword,word,half,byte}, unsigned}
- rdata1  in  XLEN  base register
- rdata2  in  XLEN  store data
- imm  in  XLEN  offset
- in_rd  in  5  destination tag, passed through
- flush  in  1  kill in-flight op
- data_sram_req  out  1  memory request
- data_sram_wr  out  1  1 = store
- data_sram_wstrb  out  SW  byte write strobes
- data_sram_addr  out  XLEN  byte address
- data_sram_wdata  out  XLEN  replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response/ack returned
- data_sram_rdata  in  XLEN  raw load data
- out_valid  out  1  result ready for WB
- out_ready  in  1  WB accepts
- out_rdata  out  XLEN  aligned, extended load result (0 for stores)
- out_rd  out  5  tag
- out_exc  out  1  misaligned or illegal-size exception
- out_badaddr  out  XLEN  faulting address

Behaviour:
- Reset values: state IDLE, all outputs 0, except in_ready=1.
- Capture: on in_valid&&in_ready, register lsu_op, addr=rdata1+imm (modulo 2^XLEN), wdata and tag.
- Size priority: byte > half > word > dword.
- Replicated store data: byte ×SW; half ×SW/2; word ×SW/4; dword = rdata2.
- Strobes: byte = 1 << off; half = 2'b11 << off; word = 4'hF << off; dword = all ones. With XLEN=32, dword is illegal.
- data_sram_addr is the full, unmasked address.
- FSM states IDLE, REQ, WAIT, DONE. in_ready=1 only in IDLE.
- IDLE → REQ: en=1 and the access is legal.
- IDLE → DONE: en=0 (pass-through, no memory access), or an exception.
- REQ: data_sram_req=1, held with address, data and strobes stable until addr_ok.
- REQ → WAIT: on addr_ok.
- REQ → DONE: on addr_ok&&data_ok in the same cycle.
- WAIT → DONE: on data_ok. Load data is latched at that edge.
- DONE: out_valid=1, held until out_ready, then → IDLE.
- Capture-to-out_valid latency is 1 cycle for en=0 or exception ops, and ≥2 cycles for memory ops.
- Load result: rdata >> (off*8), truncated to size, sign-extended unless the unsigned bit is set. lw on XLEN=32 is a plain copy.
- Stores return out_rdata=0.
- Exception: size not exactly one-hot, or dword when XLEN=32, raises out_exc=1 and badaddr=addr. No request is issued and the strobes are 0.
- Flush:
  - IDLE or DONE: → IDLE, out_valid drops next cycle.
  - REQ before addr_ok: drop the request next cycle, → IDLE.
  - REQ with addr_ok in the same cycle, or WAIT: set a cancel flag and stay until data_ok, then → IDLE with no out_valid. in_ready stays 0 meanwhile.
- Flush has priority over in_valid in the same cycle.
- data_ok is ignored in IDLE and DONE. A spurious assertion causes no state change.
- Reset mid-access clears everything. Outstanding memory responses are the memory system's responsibility.

Optional Feature:
- MISALIGN_EXC_EN.
- Defined: half with off[0]≠0, word with off[1:0]≠0, or dword with off≠0 raises out_exc with badaddr, and no request is issued.
- Undefined: misaligned accesses are issued as is. Strobes are truncated to SW bits, only the in-line bytes are written or returned, and there is no exception.

Test Plan:
- XLEN=64, sb rdata1=0x1000, imm=3, rdata2=0xAB, addr_ok and data_ok 1 cycle later. Expect: wstrb=0x08, wdata=0xABAB…AB, addr=0x1003, out_valid after data_ok, out_rdata=0.
- lh at addr 0x2006, rdata=0x8001_0000_0000_0000. Expect: out_rdata=0xFFFF_FFFF_FFFF_8001. With lhu: 0x8001.
- lw with req held 3 cycles before addr_ok. Expect: addr, wstrb and req stable throughout, then WAIT, then DONE; out_ready=0 for 2 cycles holds out_valid and out_rdata.
- Flush in WAIT, data_ok 2 cycles later. Expect: no out_valid, in_ready=0 until data_ok, then 1.
- MISALIGN_EXC_EN defined, sw at 0x1002. Expect: no data_sram_req, out_exc=1, out_badaddr=0x1002, out_valid on the next cycle.
- XLEN=32, ld op. Expect: out_exc=1, wstrb=0. en=0 op: out_valid the cycle after capture, no req.
